// File: rtl/neopixel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neopixel_pkg
// Brief    : Shared types and default timing for the WS2812 chain driver.
// Revision : 1.0 - initial release
// ============================================================================
package neopixel_pkg;

  // Transmitter phases: low reset gap, then the serial pixel stream.
  typedef enum logic [0:0] {
    LATCH = 1'b0,
    SEND  = 1'b1
  } state_t;

  // One pixel, GRB order: [23:16] green, [15:8] red, [7:0] blue.
  typedef logic [23:0] pixel_t;

  localparam int c_DEF_NUM_LEDS = 150;
  localparam int c_DEF_T0H      = 10;
  localparam int c_DEF_T1H      = 20;
  localparam int c_DEF_TBIT     = 31;
  localparam int c_DEF_TLATCH   = 1500;
  localparam int c_PIXEL_BITS   = 24;

  // Width able to index n items, never narrower than one bit.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : neopixel_pkg
`default_nettype wire

// File: rtl/neopixel_buffer.sv
`default_nettype none
// ============================================================================
// Module   : neopixel_buffer
// Brief    : Simple dual-port pixel RAM, one write port, registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module neopixel_buffer
  import neopixel_pkg::*;
#(
  parameter int DEPTH = c_DEF_NUM_LEDS,
  parameter int AW    = index_width(c_DEF_NUM_LEDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  pixel_t        i_wdata,
  input  logic [AW-1:0] i_raddr,
  output pixel_t        o_rdata
);

  // Power-up contents are all zero; nothing in the design ever clears them.
  pixel_t r_mem [DEPTH] = '{default: '0};
  pixel_t r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read-before-write: a same-cycle write to the read address returns old data.
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule : neopixel_buffer
`default_nettype wire

// File: rtl/neopixel.sv
`default_nettype none
// ============================================================================
// Module   : neopixel
// Brief    : WS2812 chain driver: pixel buffer written via an async strobe,
//            continuously streamed out as timed serial bits.
// Revision : 1.0 - initial release
// ============================================================================
module neopixel
  import neopixel_pkg::*;
#(
  parameter int NUM_LEDS = c_DEF_NUM_LEDS,
  parameter int T0H      = c_DEF_T0H,
  parameter int T1H      = c_DEF_T1H,
  parameter int TBIT     = c_DEF_TBIT,
  parameter int TLATCH   = c_DEF_TLATCH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] color,
  input  logic [15:0] address,
  input  logic        color_clock,
  output logic        leds
);

  localparam int c_AW = index_width(NUM_LEDS);
  localparam int c_CW = index_width((TLATCH > TBIT) ? TLATCH : TBIT);

  localparam logic [c_CW-1:0] c_LATCH_LAST = c_CW'(TLATCH - 1);
  localparam logic [c_CW-1:0] c_BIT_LAST   = c_CW'(TBIT - 1);
  localparam logic [c_CW-1:0] c_T0H        = c_CW'(T0H);
  localparam logic [c_CW-1:0] c_T1H        = c_CW'(T1H);
  localparam logic [c_AW-1:0] c_PIXEL_LAST = c_AW'(NUM_LEDS - 1);
  localparam logic [4:0]      c_BIT_MAX    = 5'(c_PIXEL_BITS - 1);
  localparam logic [16:0]     c_ADDR_LIMIT = 17'(NUM_LEDS);

  state_t          r_state,  w_state_n;
  logic [c_CW-1:0] r_cycle,  w_cycle_n;
  logic [4:0]      r_bit,    w_bit_n;
  logic [c_AW-1:0] r_pixel,  w_pixel_n;
  pixel_t          r_shift,  w_shift_n;
  logic            r_leds,   w_leds_n;

  logic            r_cc_meta;
  logic            r_cc_sync;
  logic            r_cc_prev;
  logic            w_wr_en;
  logic [c_AW-1:0] w_raddr;
  pixel_t          w_rdata;

  // --------------------------------------------------------------------------
  // Write side: synchronise the strobe, act on its rising edge
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cc_meta <= 1'b0;
      r_cc_sync <= 1'b0;
      r_cc_prev <= 1'b0;
    end else begin
      r_cc_meta <= color_clock;
      r_cc_sync <= r_cc_meta;
      r_cc_prev <= r_cc_sync;
    end
  end

  // The writer holds color/address stable well past the synchroniser delay.
  assign w_wr_en = ~rst & r_cc_sync & ~r_cc_prev & ({1'b0, address} < c_ADDR_LIMIT);

  neopixel_buffer #(
    .DEPTH (NUM_LEDS),
    .AW    (c_AW)
  ) u_buffer (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (address[c_AW-1:0]),
    .i_wdata (color),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // --------------------------------------------------------------------------
  // Transmitter: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LATCH;
      r_cycle <= '0;
      r_bit   <= '0;
      r_pixel <= '0;
      r_shift <= '0;
      r_leds  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cycle <= w_cycle_n;
      r_bit   <= w_bit_n;
      r_pixel <= w_pixel_n;
      r_shift <= w_shift_n;
      r_leds  <= w_leds_n;
    end
  end

  // --------------------------------------------------------------------------
  // Transmitter: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_n = r_state;
    w_cycle_n = r_cycle + c_CW'(1);
    w_bit_n   = r_bit;
    w_pixel_n = r_pixel;
    w_shift_n = r_shift;
    case (r_state)
      LATCH: begin
        if (r_cycle == c_LATCH_LAST) begin
          w_state_n = SEND;
          w_cycle_n = '0;
          w_bit_n   = '0;
          w_pixel_n = '0;
          w_shift_n = w_rdata;
        end
      end
      SEND: begin
        if (r_cycle == c_BIT_LAST) begin
          w_cycle_n = '0;
          if (r_bit == c_BIT_MAX) begin
            w_bit_n = '0;
            if (r_pixel == c_PIXEL_LAST) begin
              w_state_n = LATCH;
              w_pixel_n = '0;
            end else begin
              w_pixel_n = r_pixel + c_AW'(1);
              w_shift_n = w_rdata;
            end
          end else begin
            w_bit_n   = r_bit + 5'd1;
            w_shift_n = {r_shift[22:0], 1'b0};
          end
        end
      end
      default: begin
        w_state_n = LATCH;
        w_cycle_n = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Transmitter: outputs
  // --------------------------------------------------------------------------
  // leds is registered from the next-state values so it lines up exactly
  // with the state register and stays glitch-free on the wire.
  always_comb begin
    w_leds_n = 1'b0;
    if (w_state_n == SEND) begin
      w_leds_n = (w_cycle_n < (w_shift_n[23] ? c_T1H : c_T0H));
    end
    // Prefetch: pixel 0 during the gap, otherwise the pixel after the current one.
    w_raddr = '0;
    if ((r_state == SEND) && (r_pixel != c_PIXEL_LAST)) begin
      w_raddr = r_pixel + c_AW'(1);
    end
  end

  assign leds = r_leds;

endmodule : neopixel
`default_nettype wire

// File: tb/tb_neopixel.sv
`default_nettype none
// ============================================================================
// Module   : tb_neopixel
// Brief    : Directed self-checking bench for the WS2812 chain driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neopixel;

  localparam int NUM_LEDS = 2;
  localparam int T0H      = 10;
  localparam int T1H      = 20;
  localparam int TBIT     = 31;
  localparam int TLATCH   = 1500;
  localparam int FRAME    = TLATCH + NUM_LEDS * 24 * TBIT;
  localparam int LO_CAP   = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] color = '0;
  logic [15:0] address = '0;
  logic        color_clock = 1'b0;
  logic        leds;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int frame_start = 0;
  int m_hi [48];
  int m_lo [48];

  neopixel #(
    .NUM_LEDS (NUM_LEDS),
    .T0H      (T0H),
    .T1H      (T1H),
    .TBIT     (TBIT),
    .TLATCH   (TLATCH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .color       (color),
    .address     (address),
    .color_clock (color_clock),
    .leds        (leds)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Expected high time of frame bit b for pixel pair {p0, p1}, MSB first.
  function automatic int exp_hi(input logic [23:0] p0, input logic [23:0] p1, input int b);
    logic [47:0] f;
    f = {p0, p1};
    return f[47 - b] ? T1H : T0H;
  endfunction

  // Last bit's low phase runs into the gap, so it is measured up to the cap.
  function automatic int exp_lo(input logic [23:0] p0, input logic [23:0] p1, input int b);
    return (b == 47) ? LO_CAP : TBIT - exp_hi(p0, p1, b);
  endfunction

  task automatic write_px(input logic [15:0] a, input logic [23:0] c);
    @(negedge clk);
    address     = a;
    color       = c;
    color_clock = 1'b1;
    repeat (8) @(negedge clk);
    color_clock = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Leaves the bench at the first high sample of a frame that follows a long low gap.
  task automatic sync_frame();
    int run;
    int n;
    run = 0;
    n   = 0;
    while (!(leds === 1'b1 && run >= 1000) && n < 8000) begin
      run = (leds === 1'b0) ? run + 1 : 0;
      n++;
      @(negedge clk);
    end
    if (n >= 8000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sync_frame: no frame start within %0d cycles", n);
    end
    frame_start = cyc;
  endtask

  task automatic measure_bits();
    for (int b = 0; b < 48; b++) begin
      int h;
      int l;
      h = 0;
      l = 0;
      while (leds === 1'b1 && h < 100) begin h++; @(negedge clk); end
      while (leds === 1'b0 && l < LO_CAP) begin l++; @(negedge clk); end
      m_hi[b] = h;
      m_lo[b] = l;
    end
  endtask

  task automatic test_reset();
    int run;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (leds !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_leds: leds=%b, expected 0", leds);
      end
    end
    rst = 1'b0;
    run = 0;
    while (leds === 1'b0 && run < 3000) begin run++; @(negedge clk); end
    n_cmp++;
    if (run !== TLATCH) begin
      n_bad++;
      $display("FAIL reset_gap: low for %0d cycles, expected %0d", run, TLATCH);
    end
  endtask

  task automatic test_blank_frame();
    frame_start = cyc;
    measure_bits();
    for (int b = 0; b < 48; b++) begin
      n_cmp++;
      if (m_hi[b] !== exp_hi(24'h0, 24'h0, b) || m_lo[b] !== exp_lo(24'h0, 24'h0, b)) begin
        n_bad++;
        $display("FAIL blank_frame bit %0d: high/low %0d/%0d, expected %0d/%0d", b,
                 m_hi[b], m_lo[b], exp_hi(24'h0, 24'h0, b), exp_lo(24'h0, 24'h0, b));
      end
    end
  endtask

  task automatic test_period();
    int prev;
    prev = frame_start;
    sync_frame();
    n_cmp++;
    if (frame_start - prev !== FRAME) begin
      n_bad++;
      $display("FAIL frame_period: %0d cycles, expected %0d", frame_start - prev, FRAME);
    end
  endtask

  task automatic test_write();
    write_px(16'd0, 24'hFF0000);
    write_px(16'd1, 24'h000001);
    sync_frame();
    measure_bits();
    for (int b = 0; b < 48; b++) begin
      n_cmp++;
      if (m_hi[b] !== exp_hi(24'hFF0000, 24'h000001, b) ||
          m_lo[b] !== exp_lo(24'hFF0000, 24'h000001, b)) begin
        n_bad++;
        $display("FAIL write_frame bit %0d: high/low %0d/%0d, expected %0d/%0d", b, m_hi[b],
                 m_lo[b], exp_hi(24'hFF0000, 24'h000001, b), exp_lo(24'hFF0000, 24'h000001, b));
      end
    end
  endtask

  task automatic test_out_of_range();
    write_px(16'd2, 24'hAAAAAA);
    write_px(16'd3, 24'h555555);
    sync_frame();
    measure_bits();
    for (int b = 0; b < 48; b++) begin
      n_cmp++;
      if (m_hi[b] !== exp_hi(24'hFF0000, 24'h000001, b) ||
          m_lo[b] !== exp_lo(24'hFF0000, 24'h000001, b)) begin
        n_bad++;
        $display("FAIL out_of_range bit %0d: high/low %0d/%0d, expected %0d/%0d", b, m_hi[b],
                 m_lo[b], exp_hi(24'hFF0000, 24'h000001, b), exp_lo(24'hFF0000, 24'h000001, b));
      end
    end
  endtask

  task automatic test_write_during_tx();
    sync_frame();
    fork
      measure_bits();
      begin
        repeat (800) @(negedge clk);
        write_px(16'd1, 24'h00F00F);
      end
    join
    for (int b = 0; b < 48; b++) begin
      n_cmp++;
      if (m_hi[b] !== exp_hi(24'hFF0000, 24'h000001, b) ||
          m_lo[b] !== exp_lo(24'hFF0000, 24'h000001, b)) begin
        n_bad++;
        $display("FAIL tx_current_frame bit %0d: high/low %0d/%0d, expected %0d/%0d", b, m_hi[b],
                 m_lo[b], exp_hi(24'hFF0000, 24'h000001, b), exp_lo(24'hFF0000, 24'h000001, b));
      end
    end
    sync_frame();
    measure_bits();
    for (int b = 0; b < 48; b++) begin
      n_cmp++;
      if (m_hi[b] !== exp_hi(24'hFF0000, 24'h00F00F, b) ||
          m_lo[b] !== exp_lo(24'hFF0000, 24'h00F00F, b)) begin
        n_bad++;
        $display("FAIL tx_next_frame bit %0d: high/low %0d/%0d, expected %0d/%0d", b, m_hi[b],
                 m_lo[b], exp_hi(24'hFF0000, 24'h00F00F, b), exp_lo(24'hFF0000, 24'h00F00F, b));
      end
    end
  endtask

  task automatic test_reset_mid_bit();
    int run;
    sync_frame();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (leds !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_bit_high: leds=%b, expected 1", leds);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (leds !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_bit_abort: leds=%b, expected 0", leds);
    end
    rst = 1'b0;
    run = 0;
    while (leds === 1'b0 && run < 3000) begin run++; @(negedge clk); end
    n_cmp++;
    if (run !== TLATCH) begin
      n_bad++;
      $display("FAIL mid_bit_gap: low for %0d cycles, expected %0d", run, TLATCH);
    end
    measure_bits();
    for (int b = 0; b < 48; b++) begin
      n_cmp++;
      if (m_hi[b] !== exp_hi(24'hFF0000, 24'h00F00F, b) ||
          m_lo[b] !== exp_lo(24'hFF0000, 24'h00F00F, b)) begin
        n_bad++;
        $display("FAIL retained_frame bit %0d: high/low %0d/%0d, expected %0d/%0d", b, m_hi[b],
                 m_lo[b], exp_hi(24'hFF0000, 24'h00F00F, b), exp_lo(24'hFF0000, 24'h00F00F, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_blank_frame();
    test_period();
    test_write();
    test_out_of_range();
    test_write_during_tx();
    test_reset_mid_bit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_neopixel
`default_nettype wire

// File: doc/neopixel.md
NEOPIXEL -- requirements
Module: neopixel

Interface
REQ-001 Parameter NUM_LEDS, default 150, number of pixels in the chain and depth of the pixel buffer.
REQ-002 Parameter T0H, default 10, high time of a 0-bit in clk cycles (0.4 us at 25 MHz).
REQ-003 Parameter T1H, default 20, high time of a 1-bit in clk cycles (0.8 us).
REQ-004 Parameter TBIT, default 31, total bit period in clk cycles (1.24 us).
REQ-005 Parameter TLATCH, default 1500, low latch/reset gap between frames in clk cycles (60 us).
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  system clock, nominally 25 MHz.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 color  input  24  pixel value in GRB order: [23:16] green, [15:8] red, [7:0] blue.
REQ-010 address  input  16  pixel index to write, 0..NUM_LEDS-1.
REQ-011 color_clock  input  1  write strobe, asynchronous to clk; each rising edge writes color to address.
REQ-012 leds  output  1  serial WS2812 data line.

Function
REQ-013 color_clock SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected when the synchronized value is 1 and was 0 on the previous clk.
REQ-014 On a detected rising edge, color and address SHALL be sampled in that clk cycle and color written to buffer[address]; the writer holds color/address stable for at least 4 clk cycles after the color_clock edge.
REQ-015 Writes with address >= NUM_LEDS SHALL be ignored without side effects.
REQ-016 The buffer SHALL hold NUM_LEDS x 24 bits; all entries SHALL be 0 at configuration; rst SHALL NOT clear the buffer.
REQ-017 The transmitter SHALL run continuously with states LATCH and SEND; after rst it enters LATCH.
REQ-018 LATCH: leds low for exactly TLATCH cycles, then SEND starting at pixel 0.
REQ-019 SEND: pixels 0..NUM_LEDS-1 in ascending order, each 24 bits MSB first (bit 23 = green MSB).
REQ-020 Each bit SHALL last exactly TBIT cycles: leds high for T0H (bit 0) or T1H (bit 1) cycles, then low for the remainder.
REQ-021 Bits and pixels SHALL be back-to-back, with no extra cycles between pixels; the next pixel SHALL be prefetched from the buffer before the current pixel's last bit ends.
REQ-022 After the last bit of pixel NUM_LEDS-1, the transmitter SHALL return to LATCH, and the frame repeats indefinitely.
REQ-023 A pixel's 24-bit value SHALL be latched into the shift register when its transmission starts; writes to that pixel during its transmission take effect in the next frame.
REQ-024 A write and a read of the same buffer entry in the same cycle SHALL return the old value to the reader.
REQ-025 Frame length SHALL be TLATCH + NUM_LEDS*24*TBIT cycles.

Reset
REQ-026 While rst=1: leds=0, synchronizer flops=0, bit/pixel/cycle counters=0, state=LATCH; writes are ignored.
REQ-027 rst asserted mid-frame SHALL abort transmission immediately (leds low on the next clk edge); after release a full TLATCH gap precedes pixel 0.

Structure
REQ-028 A shared package neopixel_pkg SHALL hold the state enum (LATCH, SEND), the default timing constants, and the 24-bit GRB pixel typedef.
REQ-029 The buffer SHALL be a sub-module neopixel_buffer: a simple dual-port RAM with one write port, one synchronous read port and 1-cycle read latency.

Verification
REQ-030 NUM_LEDS=2, no writes, rst released -> leds low for 1500 cycles, then 48 bit periods each with 10 high / 21 low cycles, then low again.
REQ-031 Write 0xFF0000 to address 0 and 0x000001 to address 1 (color_clock pulses 8 cycles wide) -> next frame: 8 bits high for 20 cycles, then 16 bits of 10 cycles, then 23 bits of 10 cycles, then 1 bit of 20 cycles.
REQ-032 Write 0xAAAAAA to address 2 with NUM_LEDS=2 -> frame unchanged; no out-of-range access.
REQ-033 Write to pixel 1 while pixel 1 is transmitting -> current frame shows the old value; next frame shows the new value.
REQ-034 Assert rst for 1 cycle mid-bit while leds is high -> leds 0 on the next edge; pixel 0 restarts after 1500 low cycles; buffer contents retained.
REQ-035 Measure the period between consecutive pixel-0 starts -> exactly 1500 + 48*31 = 2988 cycles with NUM_LEDS=2.
